cnt_bank: RTL
=============

CNT_BANK -- requirements
Module: cnt_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each channel count.
REQ-002 SHALL have parameter NCH, default 4: number of independent counter channels.
REQ-003 SHALL have parameter MAX, default 200: inclusive upper count limit for all channels; elaboration SHALL fail if MAX < 1 or MAX > 2**WIDTH-1.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, NCH: per-channel count enable.
REQ-007 SHALL have port dir, input, NCH: per-channel direction, 1 = up, 0 = down.
REQ-008 SHALL have port mode, input, NCH x 2 (packed array of cnt_mode_e): per-channel WRAP, SAT or STOP.
REQ-009 SHALL have port clr, input, NCH: per-channel synchronous clear.
REQ-010 SHALL have port ld, input, NCH: per-channel synchronous load strobe.
REQ-011 SHALL have port ld_val, input, NCH x WIDTH: per-channel load value.
REQ-012 SHALL have port cnt, output, NCH x WIDTH: registered count.
REQ-013 SHALL have port at_max / at_zero, output, NCH each: combinational cnt == MAX / cnt == 0.
REQ-014 SHALL have port ovf, output, NCH: sticky boundary-event flag.
REQ-015 SHALL have port halted, output, NCH: channel frozen in STOP mode.
REQ-016 SHALL have port any_ovf, output, 1: OR-reduction of ovf.

Function
REQ-017 Per-channel priority per edge SHALL be clr > ld > en; channels fully independent.
REQ-018 clr SHALL set cnt=0, ovf=0, halted=0 at next edge, regardless of mode.
REQ-019 ld SHALL set cnt=min(ld_val, MAX), clear halted, leave ovf unchanged; 1-cycle latency.
REQ-020 en with no clr/ld and halted=0: cnt SHALL step +1 (dir=1) or -1 (dir=0) unless at boundary.
REQ-021 Boundary event: en=1 with dir=1 and cnt==MAX, or dir=0 and cnt==0; SHALL set ovf=1 at that edge in every mode.
REQ-022 WRAP at boundary SHALL go MAX->0 (up) or 0->MAX (down).
REQ-023 SAT at boundary SHALL hold cnt; reversing dir SHALL resume counting normally.
REQ-024 STOP: when cnt reaches the boundary by counting (e.g. MAX-1 -> MAX up), halted SHALL set on that same edge; while halted, en and dir ignored; exit only via clr, ld or rst.
REQ-025 Arithmetic SHALL use WIDTH+1-bit intermediates; cnt never exceeds MAX nor goes below 0.
REQ-026 mode or dir changes SHALL take effect on the next edge; no internal history beyond halted/ovf.
REQ-027 en=0 SHALL hold all channel state.

Reset
REQ-028 rst=1 SHALL asynchronously force cnt=0, ovf=0, halted=0 for all channels; any_ovf=0, at_zero=all ones, at_max=0.
REQ-029 Deassertion mid-operation SHALL resume with first count on the first edge after rst falls with en=1.
REQ-030 Assertion mid-count SHALL discard any pending ld/clr in that cycle.

Structure
REQ-031 Enum cnt_mode_e (WRAP=2'b00, SAT=2'b01, STOP=2'b10, 2'b11 treated as WRAP) SHALL live in package cnt_pkg.
REQ-032 One sub-module cnt_channel (one channel: cnt, ovf, halted) SHALL be instantiated NCH times via generate.
REQ-033 Simulation-only immediate assertions (under `ifdef sv) SHALL check cnt <= MAX every edge.

Verification
REQ-034 WIDTH=8, MAX=200, ch0 WRAP up, en=1 from 0 for 201 cycles -> cnt=0, ovf[0]=1, any_ovf=1.
REQ-035 ch1 SAT, ld_val=199, up 3 cycles -> cnt 200,200,200, ovf[1]=1; dir=0 one cycle -> cnt=199.
REQ-036 ch2 STOP down from ld_val=2, en held -> cnt 1,0, halted=1 on 0; dir=1 -> stays 0; ld 5 -> cnt=5, halted=0.
REQ-037 clr, ld and en same cycle on ch3 with cnt=7 -> cnt=0, ovf=0; ld_val=255 alone -> cnt=200.
REQ-038 rst pulsed asynchronously between edges with all channels non-zero -> all outputs at reset values immediately.
REQ-039 ch0 counting while ch1 WRAPs down at 0 -> ch1 cnt=200, ovf[1]=1; ch0 unaffected.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types for the counter bank: channel mode encoding and its normalisation.
package cnt_pkg;

  typedef enum logic [1:0] {
    WRAP = 2'b00,
    SAT  = 2'b01,
    STOP = 2'b10
  } cnt_mode_e;

  // The unused 2'b11 code behaves as WRAP.
  function automatic cnt_mode_e norm_mode(input cnt_mode_e m);
    return (m == cnt_mode_e'(2'b11)) ? WRAP : m;
  endfunction

endpackage

// File: rtl/cnt_channel.sv
// One bounded up/down counter channel with clear, load, sticky overflow and STOP halting.
module cnt_channel
  import cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  cnt_mode_e        mode,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             halted
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             halted_q, halted_d;
  logic [WIDTH:0]   up_ext, dn_ext, ld_ext;
  cnt_mode_e        mode_n;

  always_comb begin
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    halted_d = halted_q;
    mode_n   = norm_mode(mode);
    up_ext   = {1'b0, cnt_q} + 1'b1;
    dn_ext   = {1'b0, cnt_q} - 1'b1;
    ld_ext   = {1'b0, ld_val};

    if (clr) begin
      cnt_d    = '0;
      ovf_d    = 1'b0;
      halted_d = 1'b0;
    end else if (ld) begin
      cnt_d    = (ld_ext > MAX_EXT) ? MAX_W : ld_val;
      halted_d = 1'b0;
    end else if (en && !halted_q) begin
      if (dir) begin
        if (cnt_q == MAX_W) begin
          ovf_d = 1'b1;
          case (mode_n)
            SAT:     cnt_d = cnt_q;
            STOP:    halted_d = 1'b1;
            default: cnt_d = '0;
          endcase
        end else begin
          cnt_d = up_ext[WIDTH-1:0];
          // STOP freezes on the edge that lands on the limit, not one later.
          if (mode_n == STOP && up_ext == MAX_EXT) halted_d = 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          ovf_d = 1'b1;
          case (mode_n)
            SAT:     cnt_d = cnt_q;
            STOP:    halted_d = 1'b1;
            default: cnt_d = MAX_W;
          endcase
        end else begin
          cnt_d = dn_ext[WIDTH-1:0];
          if (mode_n == STOP && dn_ext == '0) halted_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      halted_q <= halted_d;
    end
  end

  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign halted = halted_q;

`ifdef sv
  always @(posedge clk) begin
    if (!rst) assert (cnt_q <= MAX_W) else $error("cnt_channel: count above MAX");
  end
`endif

endmodule

// File: rtl/cnt_bank.sv
// Bank of NCH independent bounded counters sharing one clock, reset and MAX limit.
module cnt_bank
  import cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MAX   = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic      [NCH-1:0]        en,
  input  logic      [NCH-1:0]        dir,
  input  cnt_mode_e [NCH-1:0]        mode,
  input  logic      [NCH-1:0]        clr,
  input  logic      [NCH-1:0]        ld,
  input  logic      [NCH-1:0][WIDTH-1:0] ld_val,
  output logic      [NCH-1:0][WIDTH-1:0] cnt,
  output logic      [NCH-1:0]        at_max,
  output logic      [NCH-1:0]        at_zero,
  output logic      [NCH-1:0]        ovf,
  output logic      [NCH-1:0]        halted,
  output logic                       any_ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  if (MAX < 1 || MAX > (2**WIDTH) - 1) begin : g_bad_max
    $error("cnt_bank: MAX must lie in 1 .. 2**WIDTH-1");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cnt_channel #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .dir    (dir[i]),
      .mode   (mode[i]),
      .clr    (clr[i]),
      .ld     (ld[i]),
      .ld_val (ld_val[i]),
      .cnt    (cnt[i]),
      .ovf    (ovf[i]),
      .halted (halted[i])
    );

    assign at_max[i]  = (cnt[i] == MAX_W);
    assign at_zero[i] = (cnt[i] == '0);
  end

  assign any_ovf = |ovf;

endmodule
